// File: rtl/alu_seq_ctrl_if.sv
// Bundle between the ALU sequencing controller and its environment: switch bus,
// enter button, clear, the ALU operand/result path and the registered status.
interface alu_seq_ctrl_if #(
  parameter int DW = 5
);
  logic [DW-1:0] din;
  logic          enter;
  logic          clear;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic          alu_op;
  logic [DW-1:0] alu_r;
  logic          alu_cf;
  logic          alu_sf;
  logic          alu_zf;
  logic [DW-1:0] res;
  logic          cf;
  logic          sf;
  logic          zf;
  logic          valid;
  logic [2:0]    state;
  logic [7:0]    op_count;

  // Controller side.
  modport master (
    input  din, enter, clear, alu_r, alu_cf, alu_sf, alu_zf,
    output alu_a, alu_b, alu_op, res, cf, sf, zf, valid, state, op_count
  );

  // Switches, button and ALU side.
  modport slave (
    output din, enter, clear, alu_r, alu_cf, alu_sf, alu_zf,
    input  alu_a, alu_b, alu_op, res, cf, sf, zf, valid, state, op_count
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Collects A, B and opcode from a shared switch bus on enter presses, holds them
// on the ALU for EXEC_CYCLES cycles, then registers the result and flags.
module alu_seq_ctrl #(
  parameter int DW          = 5,
  parameter int EXEC_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  alu_seq_ctrl_if.master ctrl_if
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          op_q, op_d;
  logic [DW-1:0] res_q, res_d;
  logic          cf_q, cf_d;
  logic          sf_q, sf_d;
  logic          zf_q, zf_d;
  logic          valid_q, valid_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    op_count_q, op_count_d;
  logic          s1_q, s2_q, prev_q;
  logic          enter_p;

  // The button is asynchronous; prev turns the synchronised level into one pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= ctrl_if.enter;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign enter_p = s2_q & ~prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      res_q      <= '0;
      cf_q       <= 1'b0;
      sf_q       <= 1'b0;
      zf_q       <= 1'b0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_q      <= res_d;
      cf_q       <= cf_d;
      sf_q       <= sf_d;
      zf_q       <= zf_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      op_count_q <= op_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_d      = res_q;
    cf_d       = cf_q;
    sf_d       = sf_q;
    zf_d       = zf_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    op_count_d = op_count_q;

    // clear overrides everything, including an enter pulse in the same cycle.
    if (ctrl_if.clear) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = 1'b0;
      res_d   = '0;
      cf_d    = 1'b0;
      sf_d    = 1'b0;
      zf_d    = 1'b0;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_A: begin
          if (enter_p) begin
            a_d     = ctrl_if.din;
            state_d = S_B;
          end
        end
        S_B: begin
          if (enter_p) begin
            b_d     = ctrl_if.din;
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (enter_p) begin
            op_d    = ctrl_if.din[0];
            cnt_d   = CNT_INIT;
            valid_d = 1'b0;
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            res_d   = ctrl_if.alu_r;
            cf_d    = ctrl_if.alu_cf;
            sf_d    = ctrl_if.alu_sf;
            zf_d    = ctrl_if.alu_zf;
            valid_d = 1'b1;
            if (op_count_q != 8'hFF) begin
              op_count_d = op_count_q + 8'd1;
            end
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (enter_p) begin
            valid_d = 1'b0;
            state_d = S_A;
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = S_A;
        end
      endcase
    end
  end

  assign ctrl_if.alu_a    = a_q;
  assign ctrl_if.alu_b    = b_q;
  assign ctrl_if.alu_op   = op_q;
  assign ctrl_if.res      = res_q;
  assign ctrl_if.cf       = cf_q;
  assign ctrl_if.sf       = sf_q;
  assign ctrl_if.zf       = zf_q;
  assign ctrl_if.valid    = valid_q;
  assign ctrl_if.state    = state_q;
  assign ctrl_if.op_count = op_count_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural AND/ROL ALU attached.
module tb_alu_seq_ctrl;
  localparam int DW          = 5;
  localparam int EXEC_CYCLES = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   t_exec;
  int   t_valid;
  int   exp_cnt;
  logic [DW-1:0] rot;

  alu_seq_ctrl_if #(.DW(DW)) bif ();

  alu_seq_ctrl #(.DW(DW), .EXEC_CYCLES(EXEC_CYCLES)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 5-bit ALU: AND, or rotate-left of A by B[2:0]; CF is the last bit rotated round.
  always_comb begin
    rot = bif.alu_a;
    for (int i = 0; i < 7; i++) begin
      if (i < int'(bif.alu_b[2:0])) rot = {rot[3:0], rot[4]};
    end
    if (bif.alu_op) begin
      bif.alu_r  = rot;
      bif.alu_cf = rot[0];
    end else begin
      bif.alu_r  = bif.alu_a & bif.alu_b;
      bif.alu_cf = 1'b0;
    end
    bif.alu_sf = bif.alu_r[4];
    bif.alu_zf = (bif.alu_r == '0);
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Enter held 3 cycles then released; records when EXEC and valid were first seen.
  task automatic press(input logic [DW-1:0] d);
    t_exec  = -1;
    t_valid = -1;
    @(posedge clk); #1;
    bif.din   = d;
    bif.enter = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) bif.enter = 1'b0;
      if (bif.state == 3'd3 && t_exec < 0) t_exec = i;
      if (bif.valid && t_valid < 0) t_valid = i;
    end
  endtask

  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic op);
    if (bif.state == 3'd4) press('0);
    press(a);
    press(b);
    press({4'b0000, op});
    if (exp_cnt < 255) exp_cnt++;
  endtask

  initial begin
    int found;
    checks    = 0;
    errors    = 0;
    exp_cnt   = 0;
    bif.din   = '0;
    bif.enter = 1'b0;
    bif.clear = 1'b0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", int'(bif.state), 0);
    check_eq("rst_valid", int'(bif.valid), 0);
    check_eq("rst_cnt", int'(bif.op_count), 0);
    check_eq("rst_res", int'(bif.res), 0);
    rst = 1'b0;

    // AND 10110 & 01101 = 00100
    run_op(5'b10110, 5'b01101, 1'b0);
    check_eq("and_res", int'(bif.res), 5'b00100);
    check_eq("and_cf", int'(bif.cf), 0);
    check_eq("and_sf", int'(bif.sf), 0);
    check_eq("and_zf", int'(bif.zf), 0);
    check_eq("and_valid", int'(bif.valid), 1);
    check_eq("and_cnt", int'(bif.op_count), 1);
    check_eq("and_state", int'(bif.state), 4);
    check_eq("exec_latency", t_valid - t_exec, EXEC_CYCLES);

    // ROL 10011 by 2 = 01110; ROL 01001 by 1 = 10010
    run_op(5'b10011, 5'b00010, 1'b1);
    check_eq("rol1_res", int'(bif.res), 5'b01110);
    check_eq("rol1_sf", int'(bif.sf), 0);
    check_eq("rol1_zf", int'(bif.zf), 0);
    run_op(5'b01001, 5'b00001, 1'b1);
    check_eq("rol2_res", int'(bif.res), 5'b10010);
    check_eq("rol2_sf", int'(bif.sf), 1);
    check_eq("rol2_cnt", int'(bif.op_count), 3);

    // Zero result
    run_op(5'b01010, 5'b10101, 1'b0);
    check_eq("zero_res", int'(bif.res), 0);
    check_eq("zero_zf", int'(bif.zf), 1);
    check_eq("zero_sf", int'(bif.sf), 0);
    check_eq("zero_cf", int'(bif.cf), 0);

    // Leaving DONE drops valid
    press('0);
    check_eq("leave_state", int'(bif.state), 0);
    check_eq("leave_valid", int'(bif.valid), 0);
    check_eq("leave_res_kept", int'(bif.res), 0);
    check_eq("leave_a_kept", int'(bif.alu_a), 5'b01010);

    // clear coincident with the enter pulse that would load A
    @(posedge clk); #1;
    bif.din   = 5'b11111;
    bif.enter = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bif.clear = 1'b1;
    bif.enter = 1'b0;
    @(posedge clk); #1;
    bif.clear = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("clrwin_state", int'(bif.state), 0);
    check_eq("clrwin_a", int'(bif.alu_a), 0);
    check_eq("clrwin_cnt", int'(bif.op_count), exp_cnt);

    // Hold enter for 20 cycles: only one advance
    @(posedge clk); #1;
    bif.din   = 5'b00111;
    bif.enter = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_eq("hold_state", int'(bif.state), 1);
    bif.enter = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("hold_after", int'(bif.state), 1);

    // Single-cycle pulse advances exactly once, two edges after the first sync edge
    @(posedge clk); #1;
    bif.din   = 5'b00101;
    bif.enter = 1'b1;
    @(posedge clk); #1;
    bif.enter = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("pulse_early", int'(bif.state), 1);
    @(negedge clk);
    check_eq("pulse_state", int'(bif.state), 2);
    repeat (4) @(posedge clk);

    // Second pulse lands during EXEC and must be ignored
    @(posedge clk); #1;
    bif.din   = 5'b00000;
    bif.enter = 1'b1;
    @(posedge clk); #1;
    bif.enter = 1'b0;
    @(posedge clk); #1;
    bif.enter = 1'b1;
    @(posedge clk); #1;
    bif.enter = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    exp_cnt++;
    check_eq("execpress_state", int'(bif.state), 4);
    check_eq("execpress_valid", int'(bif.valid), 1);
    check_eq("execpress_res", int'(bif.res), 5'b00101);

    // clear in S_OP
    press('0);
    press(5'b11011);
    press(5'b01110);
    check_eq("pre_clr_state", int'(bif.state), 2);
    @(posedge clk); #1;
    bif.clear = 1'b1;
    @(posedge clk); #1;
    bif.clear = 1'b0;
    @(negedge clk);
    check_eq("clr_state", int'(bif.state), 0);
    check_eq("clr_a", int'(bif.alu_a), 0);
    check_eq("clr_b", int'(bif.alu_b), 0);
    check_eq("clr_op", int'(bif.alu_op), 0);
    check_eq("clr_res", int'(bif.res), 0);
    check_eq("clr_valid", int'(bif.valid), 0);
    check_eq("clr_cnt", int'(bif.op_count), exp_cnt);

    // rst in EXEC clears outputs without waiting for a clock edge
    press(5'b10101);
    press(5'b00011);
    @(posedge clk); #1;
    bif.din   = 5'b00001;
    bif.enter = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (i == 2) bif.enter = 1'b0;
      if (bif.state == 3'd3) found = 1;
    end
    bif.enter = 1'b0;
    check_eq("exec_reach", found, 1);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_state", int'(bif.state), 0);
    check_eq("arst_valid", int'(bif.valid), 0);
    check_eq("arst_res", int'(bif.res), 0);
    check_eq("arst_a", int'(bif.alu_a), 0);
    check_eq("arst_cnt", int'(bif.op_count), 0);
    @(negedge clk);
    rst     = 1'b0;
    exp_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("post_rst_state", int'(bif.state), 0);
    press(5'b01100);
    check_eq("post_rst_loadA_state", int'(bif.state), 1);
    check_eq("post_rst_loadA_a", int'(bif.alu_a), 5'b01100);
    press(5'b00110);
    press(5'b00000);
    exp_cnt++;
    check_eq("post_rst_cnt", int'(bif.op_count), 1);

    // Saturation
    for (int n = 1; n < 257; n++) begin
      run_op(5'b11111, 5'b00001, 1'b0);
      if (n == 254) check_eq("sat_255", int'(bif.op_count), 255);
    end
    check_eq("sat_257", int'(bif.op_count), 255);
    check_eq("sat_model", int'(bif.op_count), exp_cnt);
    check_eq("sat_valid", int'(bif.valid), 1);
    press('0);
    check_eq("sat_leave_valid", int'(bif.valid), 0);
    check_eq("sat_leave_cnt", int'(bif.op_count), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
